// File: rtl/mac_ctrl.sv
// Sequencing controller and round-robin two-port arbiter for the combinational 3x3 matrix MAC.
// Optional completed-operation counter is built only when MAC_CTRL_PERF_EN is defined.
module mac_ctrl #(
   parameter int unsigned DATA_WIDTH = 72,
   parameter int unsigned LATENCY    = 2     // MAC settle cycles, 1..15
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [DATA_WIDTH-1:0] req0_mat_a_i,
   input  logic [DATA_WIDTH-1:0] req0_mat_b_i,
   input  logic [1:0]            req0_op_i,
   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [DATA_WIDTH-1:0] req1_mat_a_i,
   input  logic [DATA_WIDTH-1:0] req1_mat_b_i,
   input  logic [1:0]            req1_op_i,
   output logic [DATA_WIDTH-1:0] mac_mat_a_o,
   output logic [DATA_WIDTH-1:0] mac_mat_b_o,
   output logic [1:0]            mac_op_o,
   input  logic [DATA_WIDTH-1:0] mac_result_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_id_o,
   output logic [DATA_WIDTH-1:0] rsp_result_o,
   output logic                  rsp_err_o,
   output logic                  busy_o,
   output logic [31:0]           perf_ops_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_ILLEGAL = 2'b11;
   localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic                  rr_ptr;
   logic                  grant_vld;
   logic                  grant_id;
   logic [DATA_WIDTH-1:0] sel_a;
   logic [DATA_WIDTH-1:0] sel_b;
   logic [1:0]            sel_op;

   logic [DATA_WIDTH-1:0] mat_a_p0;
   logic [DATA_WIDTH-1:0] mat_b_p0;
   logic [1:0]            op_p0;
   logic                  id_p1;
   logic [DATA_WIDTH-1:0] result_p1;
   logic                  err_p1;
   logic                  vld_p1;

   // Arbitration: only in IDLE; a lone valid wins, a tie goes to the pointer's port.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state == IDLE) begin
         if (req0_valid_i && req1_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = rr_ptr;
         end else if (req0_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
         end else if (req1_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign req0_ready_o = grant_vld && !grant_id;
   assign req1_ready_o = grant_vld &&  grant_id;

   always_comb begin
      sel_a  = req0_mat_a_i;
      sel_b  = req0_mat_b_i;
      sel_op = req0_op_i;
      if (grant_id) begin
         sel_a  = req1_mat_a_i;
         sel_b  = req1_mat_b_i;
         sel_op = req1_op_i;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = (sel_op == OP_ILLEGAL) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (rsp_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         rr_ptr <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant_vld) begin
            rr_ptr <= ~grant_id;
            cnt    <= CNT_LOAD;
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Stage p0: operands latched on accept and held on the MAC inputs through the settle window.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mat_a_p0 <= '0;
         mat_b_p0 <= '0;
         op_p0    <= 2'b00;
      end else if (state == IDLE && grant_vld) begin
         mat_a_p0 <= sel_a;
         mat_b_p0 <= sel_b;
         op_p0    <= sel_op;
      end
   end

   // Stage p1: response buffer, filled at the end of the settle window or directly for illegal ops.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         id_p1     <= 1'b0;
         result_p1 <= '0;
         err_p1    <= 1'b0;
      end else begin
         if (state == IDLE && grant_vld) begin
            id_p1 <= grant_id;
            if (sel_op == OP_ILLEGAL) begin
               result_p1 <= '0;
               err_p1    <= 1'b1;
            end
         end else if (state == BUSY && cnt == 4'd0) begin
            result_p1 <= mac_result_i;
            err_p1    <= 1'b0;
         end
      end
   end

   assign vld_p1       = (state == DONE);
   assign mac_mat_a_o  = mat_a_p0;
   assign mac_mat_b_o  = mat_b_p0;
   assign mac_op_o     = op_p0;
   assign rsp_valid_o  = vld_p1;
   assign rsp_id_o     = id_p1;
   assign rsp_result_o = result_p1;
   assign rsp_err_o    = err_p1;
   assign busy_o       = (state != IDLE);

`ifdef MAC_CTRL_PERF_EN
   logic [31:0] perf_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_cnt <= 32'd0;
      end else if (vld_p1 && rsp_ready_i) begin
         perf_cnt <= sat_inc(perf_cnt);
      end
   end

   assign perf_ops_o = perf_cnt;
`else
   assign perf_ops_o = 32'd0;
`endif

endmodule

// File: tb/tb_mac_ctrl.sv
// Scoreboard bench for mac_ctrl with a behavioural 3x3 MAC on the mac_* interface.
module tb_mac_ctrl;
   localparam int W = 72;
   localparam int L = 2;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [1:0]    vld;
   logic [1:0]    rdy;
   logic [W-1:0]  ma [2];
   logic [W-1:0]  mb [2];
   logic [1:0]    mop [2];
   logic [W-1:0]  mac_a, mac_b, mac_res, rsp_result;
   logic [1:0]    mac_op;
   logic          rsp_valid, rsp_rdy, rsp_id, rsp_err, busy;
   logic [31:0]   perf;

   typedef struct packed {
      logic          id;
      logic [W-1:0]  res;
      logic          err;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [1:0]    op;
      logic [31:0]   t;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   n_rsp = 0;
   logic rr_model = 1'b0;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   mac_ctrl #(.DATA_WIDTH(W), .LATENCY(L)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req0_valid_i (vld[0]),
      .req0_ready_o (rdy[0]),
      .req0_mat_a_i (ma[0]),
      .req0_mat_b_i (mb[0]),
      .req0_op_i    (mop[0]),
      .req1_valid_i (vld[1]),
      .req1_ready_o (rdy[1]),
      .req1_mat_a_i (ma[1]),
      .req1_mat_b_i (mb[1]),
      .req1_op_i    (mop[1]),
      .mac_mat_a_o  (mac_a),
      .mac_mat_b_o  (mac_b),
      .mac_op_o     (mac_op),
      .mac_result_i (mac_res),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_rdy),
      .rsp_id_o     (rsp_id),
      .rsp_result_o (rsp_result),
      .rsp_err_o    (rsp_err),
      .busy_o       (busy),
      .perf_ops_o   (perf)
   );

   // Element-wise add/sub and 3x3 matrix product, all modulo 256 per element.
   function automatic logic [W-1:0] mac_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] o);
      logic [7:0]   ea [9];
      logic [7:0]   eb [9];
      logic [7:0]   v;
      logic [W-1:0] r;
      r = '0;
      for (int e = 0; e < 9; e++) begin
         ea[e] = a[W-1-8*e -: 8];
         eb[e] = b[W-1-8*e -: 8];
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            v = 8'd0;
            case (o)
               2'b00: v = ea[i*3+j] + eb[i*3+j];
               2'b01: v = ea[i*3+j] - eb[i*3+j];
               2'b10: for (int k = 0; k < 3; k++) v = v + ea[i*3+k] * eb[k*3+j];
               default: v = 8'd0;
            endcase
            r[W-1-8*(i*3+j) -: 8] = v;
         end
      end
      return r;
   endfunction

   // Illegal opcodes present garbage so a leaked MAC result is visible.
   always_comb begin
      mac_res = (mac_op == 2'b11) ? {W{1'b1}} : mac_ref(mac_a, mac_b, mac_op);
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] o, input logic [W-1:0] exp_res);
      int   n;
      exp_t e;
      vld[p] = 1'b1;
      ma[p]  = a;
      mb[p]  = b;
      mop[p] = o;
      n = 0;
      @(negedge clk_i);
      while (!rdy[p] && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      check("accept", W'(rdy[p]), W'(1));
      if (rdy[p]) begin
         if (vld == 2'b11) check("rr_grant", W'(p), W'(rr_model));
         rr_model = ~p[0];
         e.id  = p[0];
         e.res = exp_res;
         e.err = (o == 2'b11);
         e.a   = a;
         e.b   = b;
         e.op  = o;
         e.t   = 32'(cyc + 1);
         sb.push_back(e);
         grant_log.push_back(p);
      end
      @(posedge clk_i);
      #1;
      vld[p] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 200) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check("drain_busy", W'(busy), W'(0));
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   // Response monitor: sampled on the falling edge, away from the active edge.
   logic         prev_vld = 1'b0;
   logic         held = 1'b0;
   logic [W-1:0] h_res;
   logic         h_id, h_err;
   exp_t         pe;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         sb.delete();
         prev_vld = 1'b0;
         held     = 1'b0;
         n_rsp    = 0;
         rr_model = 1'b0;
      end else begin
         if (busy) check("rdy_while_busy", W'(rdy), W'(0));
         if (rdy != 2'b00) check("rdy_onehot", W'($countones(rdy)), W'(1));
         if (rsp_valid) check("busy_in_done", W'(busy), W'(1));
         if (rsp_valid && !prev_vld) begin
            check("rsp_outstanding", W'(sb.size()), W'(1));
            if (sb.size() > 0) begin
               check("rsp_latency", W'(cyc + 1), W'(sb[0].t + (sb[0].err ? 32'd1 : 32'(L + 1))));
               if (!sb[0].err) begin
                  check("mac_a", mac_a, sb[0].a);
                  check("mac_b", mac_b, sb[0].b);
                  check("mac_op", W'(mac_op), W'(sb[0].op));
               end
            end
         end
         if (held) begin
            check("hold_valid", W'(rsp_valid), W'(1));
            check("hold_result", rsp_result, h_res);
            check("hold_id", W'(rsp_id), W'(h_id));
            check("hold_err", W'(rsp_err), W'(h_err));
         end
         if (rsp_valid && rsp_rdy) begin
            if (sb.size() > 0) begin
               pe = sb.pop_front();
               check("rsp_id", W'(rsp_id), W'(pe.id));
               check("rsp_result", rsp_result, pe.res);
               check("rsp_err", W'(rsp_err), W'(pe.err));
            end
            n_rsp++;
            held = 1'b0;
         end else if (rsp_valid) begin
            held  = 1'b1;
            h_res = rsp_result;
            h_id  = rsp_id;
            h_err = rsp_err;
         end else begin
            held = 1'b0;
         end
         prev_vld = rsp_valid;
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, W'(busy), W'(0));
      check({tag, "_rsp_valid"}, W'(rsp_valid), W'(0));
      check({tag, "_rsp_result"}, rsp_result, W'(0));
      check({tag, "_rsp_err"}, W'(rsp_err), W'(0));
      check({tag, "_rsp_id"}, W'(rsp_id), W'(0));
      check({tag, "_mac_a"}, mac_a, W'(0));
      check({tag, "_mac_b"}, mac_b, W'(0));
      check({tag, "_mac_op"}, W'(mac_op), W'(0));
      check({tag, "_perf"}, W'(perf), W'(0));
   endtask

   initial begin
      logic [95:0]  r1, r2;
      logic [W-1:0] a, b;
      logic [1:0]   o;
      int           p, n;

      rst_ni  = 1'b0;
      vld     = 2'b00;
      rsp_rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ma[i]  = '0;
         mb[i]  = '0;
         mop[i] = 2'b00;
      end
      repeat (3) @(posedge clk_i);
      #1;
      check_reset_state("reset");
      rst_ni = 1'b1;

      send(0, 72'h010101010101010101, 72'h020202020202020202, 2'b00, 72'h030303030303030303);
      wait_idle();
      send(1, 72'h010000000100000001, 72'h010203040506070809, 2'b10, 72'h010203040506070809);
      wait_idle();
      send(0, 72'h0, 72'h010101010101010101, 2'b01, 72'hFFFFFFFFFFFFFFFFFF);
      wait_idle();

      // Illegal op, then a legal op whose response is backpressured for five cycles.
      send(1, 72'h0A0B0C0D0E0F101112, 72'h111111111111111111, 2'b11, 72'h0);
      wait_idle();
      rsp_rdy = 1'b0;
      a = 72'h030201_060504_090807;
      b = 72'h010203_040506_070809;
      send(0, a, b, 2'b10, mac_ref(a, b, 2'b10));
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check("bp_rsp_valid", W'(rsp_valid), W'(1));
      repeat (5) @(posedge clk_i);
      #1;
      check("bp_busy", W'(busy), W'(1));
      check("bp_rdy", W'(rdy), W'(0));
      rsp_rdy = 1'b1;
      wait_idle();

      for (int i = 0; i < 16; i++) begin
         r1 = {$urandom, $urandom, $urandom};
         r2 = {$urandom, $urandom, $urandom};
         a  = r1[W-1:0];
         b  = r2[W-1:0];
         o  = 2'($urandom_range(0, 3));
         p  = int'($urandom_range(0, 1));
         send(p, a, b, o, (o == 2'b11) ? W'(0) : mac_ref(a, b, o));
      end
      wait_idle();

      // Contention straight out of reset: both ports held valid back to back.
      do_reset();
      grant_log.delete();
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               a = {9{8'(i + 1)}};
               send(0, a, 72'h050403020100FFFEFD, (i % 2 == 0) ? 2'b00 : 2'b10,
                    mac_ref(a, 72'h050403020100FFFEFD, (i % 2 == 0) ? 2'b00 : 2'b10));
            end
         end
         begin
            for (int j = 0; j < 4; j++) begin
               send(1, 72'h102030405060708090, {9{8'(j + 7)}}, 2'b01,
                    mac_ref(72'h102030405060708090, {9{8'(j + 7)}}, 2'b01));
            end
         end
      join
      wait_idle();
      check("contend_count", W'(grant_log.size()), W'(8));
      for (int i = 0; i < grant_log.size(); i++) begin
         check("contend_grant", W'(grant_log[i]), W'(i % 2));
      end

`ifdef MAC_CTRL_PERF_EN
      check("perf_count", W'(perf), W'(n_rsp));
`else
      check("perf_count", W'(perf), W'(0));
`endif

      // Reset one cycle after accept aborts the operation.
      send(1, 72'h0F0F0F0F0F0F0F0F0F, 72'h010101010101010101, 2'b00, 72'h101010101010101010);
      check("pre_abort_busy", W'(busy), W'(1));
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      check_reset_state("abort");
      rst_ni = 1'b1;
      repeat (8) @(posedge clk_i);
      #1;
      check("abort_no_rsp", W'(rsp_valid), W'(0));
      check("abort_idle", W'(busy), W'(0));
      check("abort_sb_empty", W'(sb.size()), W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
